// File: rtl/mole_array_ctrl.sv
// Multi-hole whack-a-mole engine: LFSR hole selection, tick-timed up-window,
// hit/miss scoring with saturation, and speed levels driven by score.
module mole_array_ctrl #(
  parameter int N          = 4,
  parameter int DIV        = 50000000,
  parameter int WIN_TICKS  = 8,
  parameter int WARN_TICKS = 1,
  parameter int MAX_MISS   = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             keep_i,
  input  logic [15:0]      seed_i,
  input  logic [N-1:0]     hit_i,
  output logic [N-1:0]     mole_o,
  output logic             warn_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] score_o,
  output logic [CNT_W-1:0] miss_o,
  output logic [1:0]       level_o,
  output logic             game_over_o
);

  localparam int HW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(DIV + 1);
  localparam int WW = $clog2(WIN_TICKS + 1);
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_UP, S_GAP, S_OVER} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [N-1:0]     mole_q, mole_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] score_q, score_d, miss_q, miss_d;
  logic [1:0]       level_q, level_d;
  logic             tick_s, hit_ok_s, hit_bad_s, timeout_s;
  logic [WW-1:0]    win_len_s;
  logic [CNT_W-1:0] score_inc_s, miss_inc_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign tick_s      = ((state_q == S_UP) || (state_q == S_GAP)) && (div_q == DW'(DIV - 1)) && !keep_i;
  assign hit_ok_s    = |(hit_i & mole_q);
  assign hit_bad_s   = |(hit_i & ~mole_q);
  assign timeout_s   = tick_s && (wcnt_q == WW'(1));
  assign win_len_s   = ((WW'(WIN_TICKS) >> level_q) == WW'(0)) ? WW'(1) : (WW'(WIN_TICKS) >> level_q);
  assign score_inc_s = sat_inc(score_q);
  assign miss_inc_s  = sat_inc(miss_q);

  // Next-state, divider, window and scoring logic; en low aborts even while paused.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    lfsr_d  = lfsr_q;
    wcnt_d  = wcnt_q;
    mole_d  = mole_q;
    fail_d  = 1'b0;
    score_d = score_q;
    miss_d  = miss_q;
    level_d = level_q;
    if (!en_i) begin
      state_d = S_IDLE;
      mole_d  = {N{1'b0}};
      div_d   = {DW{1'b0}};
    end else if (keep_i) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          score_d = {CNT_W{1'b0}};
          miss_d  = {CNT_W{1'b0}};
          level_d = 2'd0;
          lfsr_d  = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
          div_d   = {DW{1'b0}};
          state_d = S_SPAWN;
        end
        S_SPAWN: begin
          mole_d  = {{(N-1){1'b0}}, 1'b1} << lfsr_q[HW-1:0];
          wcnt_d  = win_len_s;
          lfsr_d  = lfsr_step(lfsr_q);
          div_d   = {DW{1'b0}};
          state_d = S_UP;
        end
        S_UP: begin
          div_d = tick_s ? {DW{1'b0}} : div_q + DW'(1);
          if (hit_ok_s) begin
            score_d = score_inc_s;
            // Level steps only on a real increment landing on a multiple of 8.
            if ((score_inc_s != score_q) && (score_inc_s[2:0] == 3'd0) && (level_q != 2'd3)) begin
              level_d = level_q + 2'd1;
            end else begin
              level_d = level_q;
            end
            mole_d  = {N{1'b0}};
            div_d   = {DW{1'b0}};
            state_d = S_GAP;
          end else if (timeout_s) begin
            fail_d  = 1'b1;
            miss_d  = miss_inc_s;
            mole_d  = {N{1'b0}};
            div_d   = {DW{1'b0}};
            state_d = S_GAP;
          end else begin
            miss_d = hit_bad_s ? miss_inc_s : miss_q;
            wcnt_d = tick_s ? wcnt_q - WW'(1) : wcnt_q;
          end
        end
        S_GAP: begin
          div_d = tick_s ? {DW{1'b0}} : div_q + DW'(1);
          if (tick_s) begin
            state_d = (miss_q >= CNT_W'(MAX_MISS)) ? S_OVER : S_SPAWN;
          end else begin
            state_d = S_GAP;
          end
        end
        S_OVER: begin
          div_d  = {DW{1'b0}};
          mole_d = {N{1'b0}};
        end
        default: begin
          state_d = S_IDLE;
          mole_d  = {N{1'b0}};
          div_d   = {DW{1'b0}};
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      div_q   <= {DW{1'b0}};
      lfsr_q  <= 16'h0001;
      wcnt_q  <= {WW{1'b0}};
      mole_q  <= {N{1'b0}};
      fail_q  <= 1'b0;
      score_q <= {CNT_W{1'b0}};
      miss_q  <= {CNT_W{1'b0}};
      level_q <= 2'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lfsr_q  <= lfsr_d;
      wcnt_q  <= wcnt_d;
      mole_q  <= mole_d;
      fail_q  <= fail_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      level_q <= level_d;
    end
  end

  assign mole_o      = mole_q;
  assign warn_o      = (state_q == S_UP) && (wcnt_q <= WW'(WARN_TICKS));
  assign fail_o      = fail_q;
  assign score_o     = score_q;
  assign miss_o      = miss_q;
  assign level_o     = level_q;
  assign game_over_o = (state_q == S_OVER);

endmodule

// File: tb/tb_mole_array_ctrl.sv
// Bench for mole_array_ctrl: spawn holes come from a scoreboard queue filled
// from a polynomial-level LFSR model; timing and scoring checked directly.
module tb_mole_array_ctrl;
  localparam int N = 4;
  localparam int CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni, en_i, keep_i;
  logic [15:0]      seed_i;
  logic [N-1:0]     hit_i;
  logic [N-1:0]     mole_o;
  logic             warn_o, fail_o, game_over_o;
  logic [CNT_W-1:0] score_o, miss_o;
  logic [1:0]       level_o;

  int           n_checks = 0;
  int           n_errs = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] mole_prev = '0;

  mole_array_ctrl #(.N(N), .DIV(4), .WIN_TICKS(8), .WARN_TICKS(1), .MAX_MISS(3), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .keep_i(keep_i), .seed_i(seed_i),
    .hit_i(hit_i), .mole_o(mole_o), .warn_o(warn_o), .fail_o(fail_o),
    .score_o(score_o), .miss_o(miss_o), .level_o(level_o), .game_over_o(game_over_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk_i);
    #1;
  endtask

  // Expected hole sequence: x^16+x^14+x^13+x^11+1, right-shifting Galois form.
  task automatic load_spawns(input logic [15:0] seed);
    logic [15:0]  s;
    logic [N-1:0] one;
    logic         fb;
    exp_q.delete();
    one = 1;
    s = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(one << s[1:0]);
      fb = s[0];
      s = s >> 1;
      if (fb) begin
        s[15] = ~s[15]; s[13] = ~s[13]; s[12] = ~s[12]; s[10] = ~s[10];
      end
    end
  endtask

  task automatic start_game(input logic [15:0] s);
    seed_i = s;
    load_spawns(s);
    en_i = 1'b1;
    tick_clk();
  endtask

  // sel: 0 mole up, 1 warn, 2 fail, 3 game_over; n = edges waited.
  task automatic wait_for(input int sel, output int n);
    logic now;
    n = 0;
    forever begin
      case (sel)
        0: now = (mole_o != '0);
        1: now = warn_o;
        2: now = fail_o;
        default: now = game_over_o;
      endcase
      if (now) break;
      if (n >= 200) begin
        check_val("wait_budget", n, -1);
        break;
      end
      tick_clk();
      n++;
    end
  endtask

  task automatic press(input logic [N-1:0] h);
    hit_i = h;
    tick_clk();
    hit_i = '0;
  endtask

  // Scoreboard: each new mole is compared with the next queued hole.
  always @(negedge clk_i) begin
    if (mole_o != '0 && mole_prev == '0) begin
      if (exp_q.size() == 0) check_val("spawn_queue_empty", 0, 1);
      else check_val("spawn_hole", mole_o, exp_q.pop_front());
    end
    mole_prev = mole_o;
  end

  initial begin
    int n;
    logic [N-1:0] m, wrong;
    rst_ni = 1'b0; en_i = 1'b0; keep_i = 1'b0; seed_i = '0; hit_i = '0;
    repeat (3) tick_clk();
    check_val("rst_mole", mole_o, 0);
    check_val("rst_warn", warn_o, 0);
    check_val("rst_fail", fail_o, 0);
    check_val("rst_score", score_o, 0);
    check_val("rst_miss", miss_o, 0);
    check_val("rst_level", level_o, 0);
    check_val("rst_over", game_over_o, 0);
    rst_ni = 1'b1;
    tick_clk();

    // Game A: first spawn latency, hit, gap, wrong hits, hit on timeout tick.
    start_game(16'h0003);
    check_val("spawn_state_mole", mole_o, 0);
    tick_clk();
    check_val("first_mole", mole_o, 4'b1000);
    tick_clk();
    press(4'b1000);
    check_val("hit_score", score_o, 1);
    check_val("hit_mole_clr", mole_o, 0);
    wait_for(0, n);
    check_val("gap_plus_spawn", n, 5);
    m = mole_o;
    wrong = (m == 4'b0001) ? 4'b0010 : 4'b0001;
    press(wrong);
    check_val("wrong1_miss", miss_o, 1);
    check_val("wrong1_stay_up", mole_o, m);
    press(~m);
    check_val("wrong2_miss", miss_o, 2);
    check_val("wrong2_stay_up", mole_o, m);
    press(m);
    check_val("after_wrong_score", score_o, 2);
    check_val("after_wrong_miss", miss_o, 2);
    wait_for(0, n);
    m = mole_o;
    wait_for(1, n);
    check_val("warn_delay", n, 28);
    repeat (3) tick_clk();
    press(m);
    check_val("race_score", score_o, 3);
    check_val("race_miss", miss_o, 2);
    check_val("race_fail", fail_o, 0);
    tick_clk();
    check_val("race_fail_late", fail_o, 0);
    en_i = 1'b0;
    tick_clk();
    check_val("idle_mole", mole_o, 0);
    check_val("idle_score_hold", score_o, 3);
    check_val("idle_miss_hold", miss_o, 2);

    // Game B: three timeouts end the game; restart clears counters.
    start_game(16'h0000);
    check_val("restart_score", score_o, 0);
    check_val("restart_miss", miss_o, 0);
    for (int i = 0; i < 3; i++) begin
      wait_for(0, n);
      wait_for(1, n);
      check_val("to_warn", n, 28);
      wait_for(2, n);
      check_val("to_fail", n, 4);
      check_val("to_miss", miss_o, i + 1);
      check_val("to_mole", mole_o, 0);
      tick_clk();
      check_val("fail_pulse", fail_o, 0);
    end
    wait_for(3, n);
    check_val("over_delay", n, 3);
    repeat (5) tick_clk();
    check_val("over_hold", game_over_o, 1);
    check_val("over_mole", mole_o, 0);
    en_i = 1'b0;
    tick_clk();
    check_val("over_exit", game_over_o, 0);
    check_val("over_miss_hold", miss_o, 3);

    // Game C: level-up, shorter window, pause, then async reset mid-UP.
    start_game(16'hACE1);
    for (int k = 0; k < 8; k++) begin
      wait_for(0, n);
      tick_clk();
      press(mole_o);
      check_val("lvl_score", score_o, k + 1);
      check_val("lvl_level", level_o, (k == 7) ? 1 : 0);
    end
    wait_for(0, n);
    wait_for(1, n);
    check_val("l1_warn", n, 12);
    wait_for(2, n);
    check_val("l1_fail", n, 4);
    wait_for(0, n);
    m = mole_o;
    repeat (5) tick_clk();
    keep_i = 1'b1;
    repeat (8) tick_clk();
    press(m);
    repeat (11) tick_clk();
    check_val("keep_mole", mole_o, m);
    check_val("keep_score", score_o, 8);
    keep_i = 1'b0;
    wait_for(2, n);
    check_val("keep_resume", n, 11);
    check_val("keep_miss", miss_o, 2);
    wait_for(0, n);
    repeat (3) tick_clk();
    rst_ni = 1'b0;
    #1;
    check_val("arst_mole", mole_o, 0);
    check_val("arst_score", score_o, 0);
    check_val("arst_miss", miss_o, 0);
    check_val("arst_level", level_o, 0);
    check_val("arst_warn", warn_o, 0);
    repeat (2) tick_clk();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mole_array_ctrl.md
Name: mole_array_ctrl

Overview:
- Next-generation whack-a-mole game engine: drives N holes instead of one mole.
- Picks holes pseudo-randomly from a seeded LFSR and times each mole's up-window in ticks derived from the clock.
- Scores hits, counts misses and timeouts, and speeds up as score rises.
- Sits between the debounced button/switch inputs and the LED/7-seg display logic of the game top level.

Parameters:
- N, 4: number of holes; power of two, 2..16; HW = log2(N).
- DIV, 50000000: clk cycles per game tick (bench uses 4).
- WIN_TICKS, 8: mole up-window in ticks at level 0; ≥2.
- WARN_TICKS, 1: warn asserted when remaining window ≤ this.
- MAX_MISS, 3: miss count that ends the game.
- CNT_W, 8: width of score/miss counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low; all state cleared while low.
- en  in  1  run switch; rising to 1 starts a game, 0 aborts to IDLE.
- keep  in  1  pause; freezes tick divider, window counter and FSM; hits ignored.
- seed  in  16  LFSR seed, sampled on game start.
- hit  in  N  one-cycle synchronous hit pulses, one bit per hole (already debounced).
- mole  out  N  one-hot active hole, 0 when none.
- warn  out  1  mole about to time out.
- fail  out  1  one-cycle pulse on timeout.
- score  out  CNT_W  correct hits, saturating.
- miss  out  CNT_W  wrong hits + timeouts, saturating.
- level  out  2  speed level 0..3.
- game_over  out  1  high in OVER.

Behaviour:
- Reset values: mole=0, warn=0, fail=0, score=0, miss=0, level=0, game_over=0, FSM=IDLE, divider=0, lfsr=16'h0001.
- Tick generator: divider counts 0..DIV-1; tick = 1 for the cycle divider==DIV-1, then the divider wraps to 0.
  - Divider is held at 0 in IDLE, SPAWN and OVER.
  - Divider is frozen (holds its value) while keep=1.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, shifts once per SPAWN. Loaded with seed on start; seed==0 loads 16'h0001.
- Window length: win_len = max(WIN_TICKS >> level, 1).
- FSM states: IDLE, SPAWN, UP, GAP, OVER. keep=1 freezes every transition and counter update. en=0 in any state returns to IDLE next cycle with mole=0.
- IDLE:
  - All outputs at reset values except score/miss/level, which hold their last values.
  - On en=1: clear score/miss/level, load lfsr, go to SPAWN.
- SPAWN (exactly 1 cycle):
  - mole <= onehot(lfsr[HW-1:0]); wcnt <= win_len; advance lfsr; go to UP.
  - The mole is visible from the cycle after SPAWN.
- UP:
  - warn = (wcnt ≤ WARN_TICKS), combinational from wcnt.
  - On tick: wcnt decrements.
  - hit & mole != 0: score+1, mole <= 0, go to GAP.
  - hit & ~mole != 0 (a wrong hole pressed): miss+1 once per cycle regardless of how many wrong bits; stay in UP.
  - A correct and a wrong hit in the same cycle count as correct only.
  - Timeout is tick with wcnt==1: fail pulses 1 cycle, miss+1, mole <= 0, go to GAP.
  - Hit and timeout in the same cycle: the hit wins, no fail, no miss.
- GAP:
  - mole=0 and warn=0; hits are ignored.
  - Wait for 1 tick, then go to OVER if miss ≥ MAX_MISS, else to SPAWN.
- OVER: game_over=1, mole=0, hold score/miss until en=0, then go to IDLE.
- Level: when score increments to a nonzero multiple of 8, level+1, saturating at 3. A new level takes effect at the next SPAWN.
- Counters: score and miss saturate at 2^CNT_W-1; no wrap-around.
- Reset mid-game: immediate return to reset values regardless of state or keep.

Test Plan (N=4, DIV=4, WIN_TICKS=8, WARN_TICKS=1, MAX_MISS=3, CNT_W=8):
- Reset, en=1, seed=16'h0003:
  - SPAWN follows 1 cycle after start, then mole=4'b1000 (lfsr[1:0]=3) one cycle later.
  - A correct hit on the matching bit 2 cycles later gives score=1, mole=0, and a 4-cycle GAP.
- No hits after spawn:
  - warn rises when wcnt=1, i.e. 7 ticks (28 cycles) after UP entry.
  - fail pulses exactly 1 cycle at 8 ticks; miss=1; mole=0.
- Wrong hole pressed twice in UP, then correct hole → miss=2, score=1, and the state does not leave UP on the wrong hits.
- Correct hit coincident with the timeout tick → score+1, fail stays 0, miss unchanged.
- Three timeouts in a row → game_over=1 after the 3rd GAP, mole=0. en=0 then gives IDLE; en=1 restarts with score=miss=0.
- Eight correct hits:
  - level=1 and win_len=4 on the next spawn (timeout at 4 ticks).
  - keep=1 held 20 cycles mid-UP freezes wcnt, mole and divider; hits during keep are ignored.
  - Asserting rst low mid-UP clears all outputs immediately.
